// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage, the PC unit and decode.
package inst_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [2:0] {
        IF_IDLE = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        IF_HOLD = 3'd3,
        IF_HALT = 3'd4
    } if_state_e;

    // PC unit reset vector and the instruction reported when nothing is held
    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IF_NOP      = 32'h0000_0000;

    // Instruction fetches must be word aligned
    function automatic logic pc_aligned(input logic [31:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register plus a one-entry hold buffer used while decode stalls.
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP      = IF_NOP
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        load_i,       // write load data straight into id_*
    input  logic        cap_i,        // write load data into the hold buffer
    input  logic        move_i,       // move hold buffer into id_*
    input  logic        consume_i,    // decode took id_* this cycle
    input  logic        flush_i,      // drop id_* and the hold buffer
    input  logic [31:0] load_instr_i,
    input  logic [31:0] load_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);

    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic        hold_valid_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;

    // id slot: flush wins, then a fresh load, then a hold transfer, then consumption
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            id_pc_q    <= RESET_PC;
        end else if (flush_i) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
        end else if (load_i) begin
            id_valid_q <= 1'b1;
            id_instr_q <= load_instr_i;
            id_pc_q    <= load_pc_i;
        end else if (move_i && hold_valid_q) begin
            id_valid_q <= 1'b1;
            id_instr_q <= hold_instr_q;
            id_pc_q    <= hold_pc_q;
        end else if (consume_i) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
        end
    end

    // hold buffer: filled when the id slot is stalled, emptied on transfer or flush
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc_q    <= RESET_PC;
        end else if (flush_i) begin
            hold_valid_q <= 1'b0;
        end else if (cap_i) begin
            hold_valid_q <= 1'b1;
            hold_instr_q <= load_instr_i;
            hold_pc_q    <= load_pc_i;
        end else if (move_i) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign id_valid_o = id_valid_q;
    assign id_instr_o = id_instr_q;
    assign id_pc_o    = id_pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word fetches at PC, hands results to decode
// and tells the PC unit when to advance.
// Handshake: imem_req/imem_addr are held stable in REQ until imem_gnt; one
// imem_rvalid follows each grant; decode consumes id_* in any cycle with
// id_valid=1 and id_stall=0.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP      = IF_NOP
) (
    input  logic        clk,
    input  logic        PcReSet,
    input  logic [31:0] PC,
    output logic        pc_adv,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_err,
    output if_state_e   dbg_state
);

    if_state_e state_q, state_d;
    logic      discard_q, discard_d;
    logic      err_q, err_d;
    logic      load, cap, move;
    logic      consume;
    logic      slot_free;

    assign consume   = id_valid & ~id_stall;
    assign slot_free = ~id_valid | consume;

    // state, discard flag and sticky error registers
    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            state_q   <= IF_IDLE;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            err_q     <= err_d;
        end
    end

    // next state, memory request, PC advance and id register controls
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        err_d     = err_q;
        imem_req  = 1'b0;
        imem_addr = 32'h0;
        pc_adv    = 1'b0;
        load      = 1'b0;
        cap       = 1'b0;
        move      = 1'b0;
        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
            end
            IF_REQ: begin
                // a redirect suppresses the request so the new PC is fetched next
                if (flush) begin
                    state_d = IF_REQ;
                end else if (!pc_aligned(PC)) begin
                    err_d   = 1'b1;
                    state_d = IF_HALT;
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = PC;
                    if (imem_gnt) state_d = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if (flush) begin
                    // data arriving with the flush is simply dropped
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = IF_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = IF_REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (slot_free) begin
                        load   = 1'b1;
                        pc_adv = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        state_d = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (flush) begin
                    state_d = IF_REQ;
                end else if (consume) begin
                    move    = 1'b1;
                    pc_adv  = 1'b1;
                    state_d = IF_REQ;
                end
            end
            IF_HALT: begin
                if (flush) begin
                    err_d   = 1'b0;
                    state_d = IF_REQ;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) u_if_id_reg (
        .clk          (clk),
        .rst_i        (PcReSet),
        .load_i       (load),
        .cap_i        (cap),
        .move_i       (move),
        .consume_i    (consume),
        .flush_i      (flush),
        .load_instr_i (imem_rdata),
        .load_pc_i    (PC),
        .id_valid_o   (id_valid),
        .id_instr_o   (id_instr),
        .id_pc_o      (id_pc)
    );

    assign fetch_err = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for the basic fetch stream,
// hand sequences for stall, flush, misalignment and mid-fetch reset.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        PcReSet;
    logic [31:0] PC;
    logic        pc_adv;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_err;
    if_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        fl;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_adv;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    inst_fetch dut (
        .clk         (clk),
        .PcReSet     (PcReSet),
        .PC          (PC),
        .pc_adv      (pc_adv),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .fetch_err   (fetch_err),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input string name, input logic [31:0] pc, input logic gnt,
                               input logic rv, input logic [31:0] rdata, input logic stall,
                               input logic fl, input logic exp_req, input logic [31:0] exp_addr,
                               input logic exp_adv, input logic exp_valid,
                               input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                               input logic exp_err);
        vec_t r;
        r.name = name; r.pc = pc; r.gnt = gnt; r.rv = rv; r.rdata = rdata;
        r.stall = stall; r.fl = fl; r.exp_req = exp_req; r.exp_addr = exp_addr;
        r.exp_adv = exp_adv; r.exp_valid = exp_valid; r.exp_instr = exp_instr;
        r.exp_pc = exp_pc; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle: drive at negedge, check combinational outputs, then registered ones after the edge
    task automatic step(input vec_t t);
        PC          = t.pc;
        imem_gnt    = t.gnt;
        imem_rvalid = t.rv;
        imem_rdata  = t.rdata;
        id_stall    = t.stall;
        flush       = t.fl;
        #1;
        chk({t.name, ".imem_req"},  {31'b0, imem_req}, {31'b0, t.exp_req});
        chk({t.name, ".imem_addr"}, imem_addr,         t.exp_addr);
        chk({t.name, ".pc_adv"},    {31'b0, pc_adv},   {31'b0, t.exp_adv});
        @(posedge clk);
        #1;
        chk({t.name, ".id_valid"},  {31'b0, id_valid},  {31'b0, t.exp_valid});
        chk({t.name, ".id_instr"},  id_instr,           t.exp_instr);
        chk({t.name, ".id_pc"},     id_pc,              t.exp_pc);
        chk({t.name, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, t.exp_err});
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ".imem_req"},  {31'b0, imem_req},  32'h0);
        chk({name, ".imem_addr"}, imem_addr,          32'h0);
        chk({name, ".pc_adv"},    {31'b0, pc_adv},    32'h0);
        chk({name, ".id_valid"},  {31'b0, id_valid},  32'h0);
        chk({name, ".id_instr"},  id_instr,           32'h0);
        chk({name, ".id_pc"},     id_pc,              32'h0000_3000);
        chk({name, ".fetch_err"}, {31'b0, fetch_err}, 32'h0);
        chk({name, ".state"},     {29'b0, dbg_state}, {29'b0, IF_IDLE});
    endtask

    initial begin
        PcReSet = 1'b1; PC = 32'h3000; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = 0; id_stall = 0; flush = 0;

        // basic fetch stream: first word, then three more back to back
        tbl.push_back(v("idle",  32'h3000,1,1,32'hDEAD_BEEF,0,0, 0,32'h0,0,    0,32'h0,32'h3000,0));
        tbl.push_back(v("req0",  32'h3000,1,0,32'h0,0,0,         1,32'h3000,0, 0,32'h0,32'h3000,0));
        tbl.push_back(v("wait0", 32'h3000,0,1,32'h2008_0005,0,0, 0,32'h0,1,    1,32'h2008_0005,32'h3000,0));
        tbl.push_back(v("req1",  32'h3004,1,0,32'h0,0,0,         1,32'h3004,0, 0,32'h0,32'h3000,0));
        tbl.push_back(v("wait1", 32'h3004,0,1,32'h1111_0001,0,0, 0,32'h0,1,    1,32'h1111_0001,32'h3004,0));
        tbl.push_back(v("req2",  32'h3008,1,0,32'h0,0,0,         1,32'h3008,0, 0,32'h0,32'h3004,0));
        tbl.push_back(v("wait2", 32'h3008,0,1,32'h2222_0002,0,0, 0,32'h0,1,    1,32'h2222_0002,32'h3008,0));
        tbl.push_back(v("req3",  32'h300C,1,0,32'h0,0,0,         1,32'h300C,0, 0,32'h0,32'h3008,0));
        tbl.push_back(v("wait3", 32'h300C,0,1,32'h3333_0003,0,0, 0,32'h0,1,    1,32'h3333_0003,32'h300C,0));
        tbl.push_back(v("req4",  32'h3010,0,0,32'h0,0,0,         1,32'h3010,0, 0,32'h0,32'h300C,0));
        tbl.push_back(v("req4h", 32'h3010,0,0,32'h0,0,0,         1,32'h3010,0, 0,32'h0,32'h300C,0));

        // reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        PcReSet = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // decode stall while the second word returns: HOLD, then a single pc_adv
        step(v("s_req",   32'h3010,1,0,32'h0,0,0,         1,32'h3010,0, 0,32'h0,32'h300C,0));
        step(v("s_wait",  32'h3010,0,1,32'h4444_0004,0,0, 0,32'h0,1,    1,32'h4444_0004,32'h3010,0));
        step(v("s_req2",  32'h3014,1,0,32'h0,1,0,         1,32'h3014,0, 1,32'h4444_0004,32'h3010,0));
        step(v("s_wait2", 32'h3014,0,1,32'h5555_0005,1,0, 0,32'h0,0,    1,32'h4444_0004,32'h3010,0));
        for (int i = 0; i < 3; i++)
            step(v("s_hold", 32'h3014,0,0,32'h0,1,0,      0,32'h0,0,    1,32'h4444_0004,32'h3010,0));
        step(v("s_rel",   32'h3014,0,0,32'h0,0,0,         0,32'h0,1,    1,32'h5555_0005,32'h3014,0));
        step(v("s_next",  32'h3018,0,0,32'h0,0,0,         1,32'h3018,0, 0,32'h0,32'h3014,0));

        // flush in WAIT: response two cycles later is dropped, refetch at redirected PC
        step(v("f_req",   32'h3018,1,0,32'h0,0,0,         1,32'h3018,0, 0,32'h0,32'h3014,0));
        step(v("f_wait",  32'h3018,0,1,32'h6666_0006,1,0, 0,32'h0,1,    1,32'h6666_0006,32'h3018,0));
        step(v("f_req2",  32'h301C,1,0,32'h0,1,0,         1,32'h301C,0, 1,32'h6666_0006,32'h3018,0));
        step(v("f_flush", 32'h4000,0,0,32'h0,1,1,         0,32'h0,0,    0,32'h0,32'h3018,0));
        step(v("f_w1",    32'h4000,0,0,32'h0,0,0,         0,32'h0,0,    0,32'h0,32'h3018,0));
        step(v("f_drop",  32'h4000,0,1,32'h7777_0007,0,0, 0,32'h0,0,    0,32'h0,32'h3018,0));
        step(v("f_req3",  32'h4000,1,0,32'h0,0,0,         1,32'h4000,0, 0,32'h0,32'h3018,0));
        step(v("f_wait3", 32'h4000,0,1,32'h8888_0008,1,0, 0,32'h0,1,    1,32'h8888_0008,32'h4000,0));

        // flush and rvalid together while stalled: data dropped, no pc_adv
        step(v("x_req",   32'h4004,1,0,32'h0,1,0,         1,32'h4004,0, 1,32'h8888_0008,32'h4000,0));
        step(v("x_both",  32'h4004,0,1,32'h9999_0009,1,1, 0,32'h0,0,    0,32'h0,32'h4000,0));
        step(v("x_after", 32'h4004,0,0,32'h0,0,0,         1,32'h4004,0, 0,32'h0,32'h4000,0));

        // misaligned PC: no request, sticky error until flush, then a good fetch
        step(v("m_req",   32'h3002,0,0,32'h0,0,0,         0,32'h0,0,    0,32'h0,32'h4000,1));
        step(v("m_halt",  32'h3002,1,1,32'h0,0,0,         0,32'h0,0,    0,32'h0,32'h4000,1));
        step(v("m_halt2", 32'h3002,0,0,32'h0,0,0,         0,32'h0,0,    0,32'h0,32'h4000,1));
        step(v("m_flush", 32'h3004,0,0,32'h0,0,1,         0,32'h0,0,    0,32'h0,32'h4000,0));
        step(v("m_req2",  32'h3004,1,0,32'h0,0,0,         1,32'h3004,0, 0,32'h0,32'h4000,0));
        step(v("m_wait",  32'h3004,0,1,32'hAAAA_000A,1,0, 0,32'h0,1,    1,32'hAAAA_000A,32'h3004,0));

        // reset mid-WAIT: asynchronous clear, late rvalid ignored, refetch at 0x3000
        step(v("r_req",   32'h3008,1,0,32'h0,1,0,         1,32'h3008,0, 1,32'hAAAA_000A,32'h3004,0));
        imem_gnt = 0; id_stall = 0;
        PcReSet = 1'b1;
        #1;
        chk_reset_outputs("r_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("r_held");
        @(negedge clk);
        PcReSet = 1'b0;
        step(v("r_idle",  32'h3000,0,1,32'hBBBB_000B,0,0, 0,32'h0,0,    0,32'h0,32'h3000,0));
        step(v("r_req2",  32'h3000,1,0,32'h0,0,0,         1,32'h3000,0, 0,32'h0,32'h3000,0));
        step(v("r_wait",  32'h3000,0,1,32'hCCCC_000C,0,0, 0,32'h0,1,    1,32'hCCCC_000C,32'h3000,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, reset value of id_pc; matches the PC unit reset vector.
REQ-002 Parameter NOP, 32'h0000_0000, value of id_instr when no valid instruction is held.
REQ-003 clk  in  1  clock, rising-edge active.
REQ-004 PcReSet  in  1  reset, asynchronous, active-high.
REQ-005 PC  in  32  current fetch address from the PC unit.
REQ-006 pc_adv  out  1  one-cycle pulse; PC unit advances its PC at this clock edge.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  request address; equals PC while imem_req=1, else 0.
REQ-009 imem_gnt  in  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  in  1  imem_rdata valid this cycle.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 id_stall  in  1  decode cannot accept id_* this cycle.
REQ-013 flush  in  1  branch/jump redirect; discard all in-flight and held fetches.
REQ-014 id_valid  out  1  id_instr/id_pc hold a valid instruction.
REQ-015 id_instr  out  32  instruction to decode.
REQ-016 id_pc  out  32  address of id_instr.
REQ-017 fetch_err  out  1  sticky misaligned-PC error.

Function
REQ-018 States: IDLE, REQ, WAIT, HOLD, HALT; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-019 REQ: imem_req=1, imem_addr=PC; on imem_gnt go to WAIT, else remain in REQ with the request held stable.
REQ-020 REQ with PC[1:0]!=2'b00: no request issued; fetch_err set; go to HALT.
REQ-021 HALT: imem_req=0; exits only on flush (to REQ, fetch_err cleared) or reset.
REQ-022 Decode consumes id_* in any cycle with id_valid=1 and id_stall=0.
REQ-023 WAIT, imem_rvalid=1, id slot free (id_valid=0 or consumed this cycle): load id_instr=imem_rdata, id_pc=PC, id_valid=1 at the edge; pc_adv=1 combinationally that cycle; go to REQ.
REQ-024 WAIT, imem_rvalid=1, id slot occupied and stalled: capture {imem_rdata, PC} into a one-entry hold buffer; pc_adv=0; go to HOLD.
REQ-025 HOLD: in the first cycle the id slot is consumed, move the hold buffer into id_*, pc_adv=1, go to REQ.
REQ-026 id_valid clears when consumed and no new load occurs in the same cycle; id_instr then reads NOP.
REQ-027 pc_adv never asserts more than once per fetched instruction, and never for a discarded fetch.
REQ-028 flush in REQ or HOLD: id_valid=0 and hold buffer invalidated next edge; next state REQ; no pc_adv.
REQ-029 flush in WAIT: id_valid=0; set discard flag; remain in WAIT; the next imem_rvalid is dropped, discard is cleared, and the FSM goes to REQ.
REQ-030 flush and imem_rvalid in the same cycle: data dropped, no pc_adv, go to REQ; flush dominates id_stall.
REQ-031 Minimum throughput: one instruction per 2 cycles (gnt in REQ, rvalid in the next WAIT cycle).
REQ-032 All outputs except imem_req, imem_addr and pc_adv are registered.

Reset
REQ-033 PcReSet=1 immediately forces: state IDLE, id_valid=0, id_instr=NOP, id_pc=RESET_PC, hold buffer invalid, discard=0, fetch_err=0, imem_req=0, imem_addr=0, pc_adv=0.
REQ-034 Reset asserted during WAIT abandons the outstanding fetch; an imem_rvalid arriving after reset release while in IDLE is ignored.

Structure
REQ-035 Shared package: FSM state enum, RESET_PC and NOP constants, shared with the PC unit and decode.
REQ-036 One sub-module, if_id_reg: the id_* register plus the hold buffer with load/consume/flush controls; the FSM stays in inst_fetch.

Verification
REQ-037 Reset, then PC=0x3000, gnt in REQ, rvalid with rdata=0x2008_0005 in the next cycle -> pc_adv pulse, id_valid=1, id_pc=0x3000, id_instr=0x2008_0005.
REQ-038 Fetch four sequential words with id_stall=0 and zero-wait memory -> one pc_adv per word, one instruction every 2 cycles, id_pc steps 0x3000..0x300C.
REQ-039 id_stall=1 held for 5 cycles while the second word returns -> HOLD entered, no pc_adv; on stall release, second word appears in id_* with a single pc_adv.
REQ-040 flush asserted in WAIT, rvalid 2 cycles later -> word dropped, no pc_adv, id_valid=0, new REQ issued at the redirected PC.
REQ-041 PC=0x3002 in REQ -> imem_req stays 0, fetch_err=1 until flush; then a fetch at PC=0x3004 succeeds.
REQ-042 PcReSet pulsed mid-WAIT -> all outputs at reset values asynchronously; a late rvalid is ignored; the first fetch after reset is at 0x3000.
